// File: rtl/fib_wb_responder.sv
// Wishbone classic responder for an iterative Fibonacci engine.
// The host writes n and START to CTRL, polls STATUS (or waits on irq_o) and
// reads fib(n) mod 2**FN_W from RESULT.
// Optional feature macro: FIB_WB_IRQ_EN (IE bit and irq_o = DONE & IE).
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i    bus cycle, strobe, write enable
//   wbs_sel_i[3:0]          byte-lane enables for writes
//   wbs_adr_i[31:0]         byte address, register offset in [3:2]
//   wbs_dat_i[31:0]         write data
//   wbs_ack_o               single-cycle acknowledge
//   wbs_dat_o[31:0]         read data, zero outside ack
//   irq_o                   level interrupt
module fib_wb_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned N_W       = 8,
  parameter int unsigned FN_W      = 32
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_RESULT = 2'd2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]      state, state_nxt;
  logic [N_W-1:0]  n_reg, n_nxt;
  logic [N_W-1:0]  cnt, cnt_nxt;
  logic [N_W-1:0]  iter, iter_nxt;
  logic [FN_W-1:0] a, a_nxt, b, b_nxt;
  logic [FN_W-1:0] result, result_nxt;
  logic            a_ovf, a_ovf_nxt, b_ovf, b_ovf_nxt;
  logic            done, done_nxt, ovf, ovf_nxt;
  logic            ack_nxt, irq_nxt;
  logic [31:0]     dat_nxt;

  logic            addr_hit_c, req_c, wr_c;
  logic [1:0]      off_c;
  logic [FN_W:0]   sum_c;
  logic [31:0]     rdata_c;

`ifdef FIB_WB_IRQ_EN
  logic ie, ie_nxt;
  logic unused_bits;
  assign unused_bits = ^{wbs_dat_i[31:10], wbs_adr_i[1:0], wbs_sel_i[3:2]};
`else
  logic ie;
  logic unused_bits;
  assign ie          = 1'b0;
  assign unused_bits = ^{wbs_dat_i[31:9], wbs_adr_i[1:0], wbs_sel_i[3:2]};
`endif

  // Request decode; ~ack enforces one access per two cycles
  assign addr_hit_c = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign req_c      = wbs_cyc_i & wbs_stb_i & addr_hit_c & ~wbs_ack_o;
  assign wr_c       = req_c & wbs_we_i;
  assign off_c      = wbs_adr_i[3:2];
  // Extra MSB carries the overflow of the b-path addition
  assign sum_c      = {1'b0, a} + {1'b0, b};

  // Read mux, sampled from pre-edge register values
  always_comb begin
    rdata_c = '0;
    case (off_c)
      OFF_CTRL: begin
        rdata_c[N_W-1:0] = n_reg;
        rdata_c[9]       = ie;
      end
      OFF_STATUS: rdata_c[2:0] = {ovf, (state == ST_RUN), done};
      OFF_RESULT: rdata_c = 32'(result);
      default:    rdata_c = 32'(iter);
    endcase
  end

  // Next-state: bus writes first, then the engine step so completion wins
  always_comb begin
    state_nxt  = state;
    n_nxt      = n_reg;
    cnt_nxt    = cnt;
    iter_nxt   = iter;
    a_nxt      = a;
    b_nxt      = b;
    a_ovf_nxt  = a_ovf;
    b_ovf_nxt  = b_ovf;
    result_nxt = result;
    done_nxt   = done;
    ovf_nxt    = ovf;
`ifdef FIB_WB_IRQ_EN
    ie_nxt     = ie;
`endif
    ack_nxt    = req_c;
    dat_nxt    = (req_c && !wbs_we_i) ? rdata_c : 32'h0;

    if (wr_c) begin
      case (off_c)
        OFF_CTRL: begin
          if (wbs_sel_i[0]) n_nxt = wbs_dat_i[N_W-1:0];
          if (wbs_sel_i[1]) begin
`ifdef FIB_WB_IRQ_EN
            ie_nxt = wbs_dat_i[9];
`endif
            if (wbs_dat_i[8] && state == ST_IDLE) begin
              state_nxt = ST_RUN;
              a_nxt     = '0;
              b_nxt     = FN_W'(1);
              a_ovf_nxt = 1'b0;
              b_ovf_nxt = 1'b0;
              cnt_nxt   = wbs_sel_i[0] ? wbs_dat_i[N_W-1:0] : n_reg;
              iter_nxt  = '0;
              done_nxt  = 1'b0;
              ovf_nxt   = 1'b0;
            end
          end
        end
        OFF_STATUS: begin
          if (wbs_sel_i[0]) begin
            if (wbs_dat_i[0]) done_nxt = 1'b0;
            if (wbs_dat_i[2]) ovf_nxt  = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (state == ST_RUN) begin
      if (cnt == '0) begin
        result_nxt = a;
        done_nxt   = 1'b1;
        ovf_nxt    = a_ovf;
        state_nxt  = ST_IDLE;
      end else begin
        a_nxt     = b;
        b_nxt     = sum_c[FN_W-1:0];
        // Overflow flag follows the same a/b shift as the values
        a_ovf_nxt = b_ovf;
        b_ovf_nxt = a_ovf | b_ovf | sum_c[FN_W];
        cnt_nxt   = cnt - N_W'(1);
        iter_nxt  = iter + N_W'(1);
      end
    end

`ifdef FIB_WB_IRQ_EN
    irq_nxt = done_nxt & ie_nxt;
`else
    irq_nxt = 1'b0;
`endif
  end

  // State and output registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      n_reg     <= '0;
      cnt       <= '0;
      iter      <= '0;
      a         <= '0;
      b         <= '0;
      a_ovf     <= 1'b0;
      b_ovf     <= 1'b0;
      result    <= '0;
      done      <= 1'b0;
      ovf       <= 1'b0;
`ifdef FIB_WB_IRQ_EN
      ie        <= 1'b0;
`endif
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
      irq_o     <= 1'b0;
    end else begin
      state     <= state_nxt;
      n_reg     <= n_nxt;
      cnt       <= cnt_nxt;
      iter      <= iter_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      a_ovf     <= a_ovf_nxt;
      b_ovf     <= b_ovf_nxt;
      result    <= result_nxt;
      done      <= done_nxt;
      ovf       <= ovf_nxt;
`ifdef FIB_WB_IRQ_EN
      ie        <= ie_nxt;
`endif
      wbs_ack_o <= ack_nxt;
      wbs_dat_o <= dat_nxt;
      irq_o     <= irq_nxt;
    end
  end

endmodule

// File: tb/tb_fib_wb_responder.sv
// Self-checking bench for fib_wb_responder: directed register-map scenarios
// plus randomized n values checked against a table-based Fibonacci model.
module tb_fib_wb_responder;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] CTRL   = BASE + 32'h0;
  localparam logic [31:0] STATUS = BASE + 32'h4;
  localparam logic [31:0] RESULT = BASE + 32'h8;
  localparam logic [31:0] ITER   = BASE + 32'hC;
`ifdef FIB_WB_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk, rst, cyc, stb, we, ack, irq;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w, dat_r;
  int          tests, fails, cyc_cnt;

  // Model tables: value mod 2**32 and true value saturated at 2**33
  logic [31:0]     fib_mod [0:255];
  longint unsigned fib_sat [0:255];

  fib_wb_responder dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_w),
    .wbs_ack_o(ack), .wbs_dat_o(dat_r), .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus access; edge_idx is the clock edge that sampled the request
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output int edge_idx);
    int waits;
    waits = 0; rd = '0; edge_idx = -1;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    do begin
      @(negedge clk);
      waits++;
    end while (!ack && waits < 6);
    if (ack) begin
      rd = dat_r;
      edge_idx = cyc_cnt;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("ack_latency", 32'(waits), 32'd1);
    @(negedge clk);
    chk("ack_single", 32'(ack), 32'd0);
    chk("dat_idle", dat_r, 32'h0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    int e;
    wb_xfer(1'b0, a, 32'h0, 4'hF, v, e);
    chk(tag, v, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    int e;
    wb_xfer(1'b1, a, d, s, v, e);
  endtask

  // Poll STATUS and check BUSY/DONE against the edge-accurate timeline
  task automatic poll_done(input int n, input int s_edge);
    logic [31:0] st;
    int e;
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      wb_xfer(1'b0, STATUS, 32'h0, 4'hF, st, e);
      chk("poll_busy", 32'(st[1]), 32'(e >= s_edge + 1 && e <= s_edge + n + 1));
      chk("poll_done", 32'(st[0]), 32'(e >= s_edge + n + 2));
      if (st[0]) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic run_check(input int n, input logic [3:0] s, input logic [31:0] extra);
    logic [31:0] v;
    int s_edge;
    logic ovf_exp;
    wb_xfer(1'b1, CTRL, extra | 32'h100 | 32'(n), s, v, s_edge);
    poll_done(n, s_edge);
    ovf_exp = (fib_sat[n] >= 64'h1_0000_0000);
    rd_chk("status_end", STATUS, {29'h0, ovf_exp, 2'b01});
    rd_chk("result", RESULT, fib_mod[n]);
    rd_chk("iter", ITER, 32'(n));
  endtask

  initial begin
    logic [31:0] v;
    int s_edge, e, n;
    tests = 0; fails = 0;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_w = '0;

    fib_mod[0] = 32'd0; fib_mod[1] = 32'd1;
    fib_sat[0] = 0;     fib_sat[1] = 1;
    for (int i = 2; i < 256; i++) begin
      fib_mod[i] = fib_mod[i-1] + fib_mod[i-2];
      fib_sat[i] = fib_sat[i-1] + fib_sat[i-2];
      if (fib_sat[i] > 64'h2_0000_0000) fib_sat[i] = 64'h2_0000_0000;
    end

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", dat_r, 32'h0);
    chk("rst_irq", 32'(irq), 32'd0);
    rd_chk("rst_ctrl", CTRL, 32'h0);
    rd_chk("rst_status", STATUS, 32'h0);
    rd_chk("rst_result", RESULT, 32'h0);
    rd_chk("rst_iter", ITER, 32'h0);

    // Miss on address and strobe without cyc: no ack, no side effect
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h10; dat_w = 32'h105; sel = 4'h3;
    repeat (4) begin
      @(negedge clk);
      chk("miss_noack", 32'(ack), 32'd0);
    end
    cyc = 1'b0; adr = CTRL;
    repeat (3) begin
      @(negedge clk);
      chk("nocyc_noack", 32'(ack), 32'd0);
    end
    stb = 1'b0; we = 1'b0;
    rd_chk("miss_status", STATUS, 32'h0);
    rd_chk("miss_ctrl", CTRL, 32'h0);

    // n=10 run with edge-accurate BUSY/DONE timing
    run_check(10, 4'h3, 32'h0);
    rd_chk("t2_result", RESULT, 32'h0000_0037);
    rd_chk("t2_ctrl", CTRL, 32'h0000_000A);

    // Boundary n values
    run_check(47, 4'h3, 32'h0);
    rd_chk("t3_47", RESULT, 32'hB119_24E1);
    run_check(48, 4'h3, 32'h0);
    rd_chk("t3_48", RESULT, 32'h1E8D_0A40);
    rd_chk("t3_48_ovf", STATUS, 32'h5);
    run_check(0, 4'h3, 32'h0);
    rd_chk("t3_0", RESULT, 32'h0);

    // START with only sel[1] uses the stored n
    wr(CTRL, 32'h0000_0007, 4'h1);
    wb_xfer(1'b1, CTRL, 32'h0000_0100, 4'h2, v, s_edge);
    poll_done(7, s_edge);
    rd_chk("sel1_start", RESULT, 32'd13);

    // START while busy is ignored but n_reg still updates
    wb_xfer(1'b1, CTRL, 32'h0000_0114, 4'h3, v, s_edge);
    wr(CTRL, 32'h0000_0105, 4'h3);
    poll_done(20, s_edge);
    rd_chk("t4_result", RESULT, 32'h0000_1A6D);
    rd_chk("t4_iter", ITER, 32'd20);
    rd_chk("t4_ctrl", CTRL, 32'h0000_0005);

    // DONE W1C on the completion edge: DONE survives
    wb_xfer(1'b1, CTRL, 32'h0000_010A, 4'h3, v, s_edge);
    while (cyc_cnt < s_edge + 9) @(negedge clk);
    wb_xfer(1'b1, STATUS, 32'h1, 4'h1, v, e);
    chk("w1c_edge", 32'(e), 32'(s_edge + 11));
    rd_chk("w1c_race", STATUS, 32'h1);
    wr(STATUS, 32'h5, 4'h2);
    rd_chk("w1c_nosel", STATUS, 32'h1);
    wr(STATUS, 32'h5, 4'h1);
    rd_chk("w1c_clear", STATUS, 32'h0);

    // STATUS read sampled on the completion edge returns pre-edge value
    wb_xfer(1'b1, CTRL, 32'h0000_010A, 4'h3, v, s_edge);
    while (cyc_cnt < s_edge + 9) @(negedge clk);
    wb_xfer(1'b0, STATUS, 32'h0, 4'hF, v, e);
    chk("pre_edge_idx", 32'(e), 32'(s_edge + 11));
    chk("pre_edge_val", v, 32'h2);
    rd_chk("post_edge", STATUS, 32'h1);

    // Reset mid-run drops the run and a pending request
    wb_xfer(1'b1, CTRL, 32'h0000_011E, 4'h3, v, s_edge);
    repeat (9) @(negedge clk);
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = STATUS;
    @(negedge clk);
    chk("rst_pending_ack", 32'(ack), 32'd0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    rd_chk("t5_status", STATUS, 32'h0);
    rd_chk("t5_result", RESULT, 32'h0);
    rd_chk("t5_iter", ITER, 32'h0);
    rd_chk("t5_ctrl", CTRL, 32'h0);
    run_check(3, 4'h3, 32'h0);
    rd_chk("t5_n3", RESULT, 32'd2);

    // Interrupt
    chk("irq_idle", 32'(irq), 32'd0);
    wb_xfer(1'b1, CTRL, 32'h0000_030C, 4'h3, v, s_edge);
    poll_done(12, s_edge);
    @(negedge clk);
    chk("irq_done", 32'(irq), 32'(IRQ_ON));
    rd_chk("t6_result", RESULT, 32'h90);
    rd_chk("t6_ctrl", CTRL, IRQ_ON ? 32'h20C : 32'h00C);
    wr(STATUS, 32'h1, 4'h1);
    @(negedge clk);
    chk("irq_clear", 32'(irq), 32'd0);

    // Randomized n (also clears IE)
    for (int k = 0; k < 12; k++) begin
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(61, 255)) : int'($urandom_range(0, 60));
      run_check(n, 4'h3, 32'h0);
      chk("rand_irq", 32'(irq), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
